// File: rtl/inst_buffer_pkg.sv
// Shared types for the instruction buffer.
// fb_entry_t : one fetched instruction together with the PC it came from.
package inst_buffer_pkg;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fb_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode.
// Whole fetch bundles are stored in program order. Up to OUT_WIDTH of the
// oldest entries are presented to decode every cycle. Outputs come from
// registered state only, so a bundle never bypasses straight to decode.
//
// Ports
//   clock           : clock, all state changes on the rising edge
//   reset_n         : synchronous active-low reset (overrides flush)
//   flush           : drop all contents at the next edge, mask outputs now
//   insts_in        : fetch bundle, lane 0 oldest
//   insts_in_valid  : bundle offered this cycle
//   full            : fewer than IN_WIDTH free entries (fetch stall)
//   decode_stall    : decode takes nothing this cycle
//   insts_out       : oldest entries, lane 0 is the head
//   insts_out_valid : thermometer mask of valid output lanes
//   entry_count     : current occupancy
//
// DEPTH must be a power of two and at least IN_WIDTH + OUT_WIDTH.
`ifndef FECTH_WIDTH
`define FECTH_WIDTH 2
`endif

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int IN_WIDTH  = `FECTH_WIDTH,
  parameter int OUT_WIDTH = 4,
  parameter int DEPTH     = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  fb_entry_t [IN_WIDTH-1:0]      insts_in,
  input  logic                          insts_in_valid,
  output logic                          full,
  input  logic                          decode_stall,
  output fb_entry_t [OUT_WIDTH-1:0]     insts_out,
  output logic [OUT_WIDTH-1:0]          insts_out_valid,
  output logic [$clog2(DEPTH):0]        entry_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] IN_C    = CW'(IN_WIDTH);
  localparam logic [CW-1:0] OUT_C   = CW'(OUT_WIDTH);

  fb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic [CW-1:0] avail;
  logic [CW-1:0] deq_n;
  logic          enq;

  // full looks at pre-dequeue occupancy only, so it is conservative and has
  // no combinational dependence on decode_stall or insts_in_valid.
  assign full        = (DEPTH_C - count) < IN_C;
  assign enq         = insts_in_valid && !full;
  assign entry_count = count;

  always_comb begin
    avail           = (count < OUT_C) ? count : OUT_C;
    deq_n           = decode_stall ? '0 : avail;
    insts_out       = '0;
    insts_out_valid = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      insts_out[i]       = mem[head + PW'(i)];
      insts_out_valid[i] = (CW'(i) < avail) && !flush;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // deq_n never exceeds OUT_WIDTH < DEPTH, so truncation is exact.
      head  <= head + PW'(deq_n);
      if (enq) begin
        tail <= tail + PW'(IN_WIDTH);
      end
      count <= count + (enq ? IN_C : '0) - deq_n;
    end
  end

  // Storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (reset_n && !flush && enq) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
        mem[tail + PW'(j)] <= insts_in[j];
      end
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int IN_W  = 2;
  localparam int OUT_W = 3;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic                    flush;
  fb_entry_t [IN_W-1:0]    insts_in;
  logic                    insts_in_valid;
  logic                    full;
  logic                    decode_stall;
  fb_entry_t [OUT_W-1:0]   insts_out;
  logic [OUT_W-1:0]        insts_out_valid;
  logic [CW-1:0]           entry_count;

  inst_buffer #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .flush           (flush),
    .insts_in        (insts_in),
    .insts_in_valid  (insts_in_valid),
    .full            (full),
    .decode_stall    (decode_stall),
    .insts_out       (insts_out),
    .insts_out_valid (insts_out_valid),
    .entry_count     (entry_count)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit r, bit f, bit v, bit s, logic [31:0] pc);
    reset_n        = r;
    flush          = f;
    insts_in_valid = v;
    decode_stall   = s;
    insts_in[0].pc   = pc;
    insts_in[0].inst = ~pc;
    insts_in[1].pc   = pc + 32'd4;
    insts_in[1].inst = ~(pc + 32'd4);
  endtask

  // Reference model: program-ordered list of buffered PCs.
  logic [31:0] q[$];

  function automatic int model_avail();
    return (q.size() < OUT_W) ? q.size() : OUT_W;
  endfunction

  function automatic bit model_full();
    return (DEPTH - q.size()) < IN_W;
  endfunction

  task automatic check_model(string tag);
    int a;
    logic [2:0] m;
    a = model_avail();
    m = flush ? 3'b000 : 3'((1 << a) - 1);
    check({tag, " count"}, 32'(entry_count), 32'(q.size()));
    check({tag, " full"},  32'(full), 32'(model_full()));
    check({tag, " valid"}, 32'(insts_out_valid), 32'(m));
    if (!flush) begin
      for (int i = 0; i < a; i++) begin
        check($sformatf("%s lane%0d pc", tag, i), insts_out[i].pc, q[i]);
        check($sformatf("%s lane%0d inst", tag, i), insts_out[i].inst, ~q[i]);
      end
    end
  endtask

  task automatic step_model();
    int d;
    bit e;
    if (!reset_n || flush) begin
      q.delete();
    end else begin
      e = insts_in_valid && !model_full();
      d = decode_stall ? 0 : model_avail();
      repeat (d) void'(q.pop_front());
      if (e) begin
        q.push_back(insts_in[0].pc);
        q.push_back(insts_in[1].pc);
      end
    end
  endtask

  task automatic tick();
    step_model();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    bit               rst_n, fl, v, st;
    logic [31:0]      pc;
    int               ecount;
    bit               efull;
    logic [2:0]       evalid;
    logic [2:0][31:0] epc;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, bit v, bit s, logic [31:0] pc,
                              int c, bit fu, logic [2:0] ev,
                              logic [31:0] p0, logic [31:0] p1, logic [31:0] p2);
    vec_t t;
    t.rst_n = r; t.fl = f; t.v = v; t.st = s; t.pc = pc;
    t.ecount = c; t.efull = fu; t.evalid = ev;
    t.epc[0] = p0; t.epc[1] = p1; t.epc[2] = p2;
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [31:0] got[$];
    logic [31:0] pc_next;
    int sent;
    int cyc;
    bit done;

    // Outputs observed in the row's cycle, before the edge that applies its inputs.
    //                 r f v s  pc         cnt full valid   pc0        pc1        pc2
    vecs.push_back(mk(0,0,1,1, 32'h80,    0, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1,0,1,1, 32'h0,     0, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1,0,1,1, 32'h8,     2, 0, 3'b011, 32'h0,   32'h4,   0));
    vecs.push_back(mk(1,0,1,1, 32'h10,    4, 0, 3'b111, 32'h0,   32'h4,   32'h8));
    vecs.push_back(mk(1,0,1,1, 32'h18,    6, 0, 3'b111, 32'h0,   32'h4,   32'h8));
    vecs.push_back(mk(1,0,1,1, 32'h20,    8, 1, 3'b111, 32'h0,   32'h4,   32'h8));
    vecs.push_back(mk(1,0,0,1, 32'h0,     8, 1, 3'b111, 32'h0,   32'h4,   32'h8));
    vecs.push_back(mk(1,0,1,0, 32'h20,    8, 1, 3'b111, 32'h0,   32'h4,   32'h8));
    vecs.push_back(mk(1,0,1,0, 32'h20,    5, 0, 3'b111, 32'hC,   32'h10,  32'h14));
    vecs.push_back(mk(1,0,1,1, 32'h28,    4, 0, 3'b111, 32'h18,  32'h1C,  32'h20));
    vecs.push_back(mk(1,1,1,0, 32'h30,    6, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1,0,1,0, 32'h100,   0, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1,0,0,0, 32'h0,     2, 0, 3'b011, 32'h100, 32'h104, 0));
    vecs.push_back(mk(1,0,1,1, 32'h200,   0, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(1,0,1,1, 32'h208,   2, 0, 3'b011, 32'h200, 32'h204, 0));
    vecs.push_back(mk(1,0,0,0, 32'h0,     4, 0, 3'b111, 32'h200, 32'h204, 32'h208));
    vecs.push_back(mk(1,0,0,0, 32'h0,     1, 0, 3'b001, 32'h20C, 0, 0));
    vecs.push_back(mk(1,0,1,1, 32'h300,   0, 0, 3'b000, 0, 0, 0));
    vecs.push_back(mk(0,0,1,1, 32'h308,   2, 0, 3'b011, 32'h300, 32'h304, 0));
    vecs.push_back(mk(1,0,0,1, 32'h0,     0, 0, 3'b000, 0, 0, 0));

    drive(0, 0, 0, 1, 32'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    q.delete();

    foreach (vecs[k]) begin
      drive(vecs[k].rst_n, vecs[k].fl, vecs[k].v, vecs[k].st, vecs[k].pc);
      #3;
      check($sformatf("row%0d count", k), 32'(entry_count), 32'(vecs[k].ecount));
      check($sformatf("row%0d full", k), 32'(full), 32'(vecs[k].efull));
      check($sformatf("row%0d valid", k), 32'(insts_out_valid), 32'(vecs[k].evalid));
      for (int i = 0; i < OUT_W; i++) begin
        if (vecs[k].evalid[i]) begin
          check($sformatf("row%0d lane%0d pc", k, i), insts_out[i].pc, vecs[k].epc[i]);
          check($sformatf("row%0d lane%0d inst", k, i), insts_out[i].inst, ~vecs[k].epc[i]);
        end
      end
      tick();
    end

    // Wrap-around stream: 20 instructions, decode stalling in 2-cycle bursts.
    drive(0, 0, 0, 1, 32'h0);
    tick();
    sent = 0;
    done = 0;
    for (cyc = 0; cyc < 200 && !done; cyc++) begin
      drive(1, 0, (sent < 20) && !model_full(), ((cyc / 2) % 2) == 1, 32'(sent * 4));
      #3;
      check_model($sformatf("wrap c%0d", cyc));
      if (!decode_stall) begin
        for (int i = 0; i < OUT_W; i++) begin
          if (insts_out_valid[i]) got.push_back(insts_out[i].pc);
        end
      end
      if (insts_in_valid) sent += 2;
      tick();
      if (got.size() >= 20 && sent >= 20) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wrap timeout: got %0d entries expected 20", got.size());
    end
    check("wrap delivered", 32'(got.size()), 32'd20);
    for (int i = 0; i < got.size() && i < 20; i++) begin
      check($sformatf("wrap order %0d", i), got[i], 32'(i * 4));
    end

    // Randomized traffic against the model.
    pc_next = 32'h1000;
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 63) != 0, $urandom_range(0, 31) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, pc_next);
      #3;
      check_model($sformatf("rand c%0d", c));
      if (reset_n && !flush && insts_in_valid && !model_full()) pc_next += 32'd8;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
# inst_buffer

Circular FIFO between `inst_fetch` and decode. Each accepted fetch bundle of `fb_entry_t` (instruction plus PC) is stored in program order, and up to `OUT_WIDTH` entries per cycle are presented to decode. The block drives the fetch-side `stall` as a space-based full signal and is flushed on redirect (branch taken or mispredict). Data is registered, so there is no bypass from input to output.

## Interface
Parameters:
- `IN_WIDTH`, default `` `FECTH_WIDTH ``: entries offered per fetch bundle.
- `OUT_WIDTH`, default 4: maximum entries presented to decode per cycle.
- `DEPTH`, default 16: storage entries. Must be a power of 2 and at least `IN_WIDTH + OUT_WIDTH`.

Ports:
- `clock`  in  1  the single clock; all state updates on posedge.
- `reset_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  discard all contents at the next edge.
- `insts_in`  in  `fb_entry_t [IN_WIDTH-1:0]`  fetch bundle; lane 0 is the oldest.
- `insts_in_valid`  in  1  the bundle is offered this cycle.
- `full`  out  1  free entries < `IN_WIDTH`; wired to `inst_fetch.stall`.
- `decode_stall`  in  1  decode accepts nothing this cycle.
- `insts_out`  out  `fb_entry_t [OUT_WIDTH-1:0]`  oldest entries; lane 0 is the head.
- `insts_out_valid`  out  `OUT_WIDTH`  thermometer mask of valid lanes.
- `entry_count`  out  `$clog2(DEPTH)+1`  current occupancy.

## Operation
- State:
  - `head` and `tail` pointers, `$clog2(DEPTH)` bits each, wrapping modulo `DEPTH`.
  - `count`, 0..`DEPTH`.
  - Entry array with no per-entry valid bits.
- Combinational outputs, derived from registered state only:
  - `full = (DEPTH - count) < IN_WIDTH`.
  - `avail = min(count, OUT_WIDTH)`.
  - `insts_out[i] = mem[(head+i) mod DEPTH]`.
  - `insts_out_valid[i] = (i < avail) & ~flush`.
  - Data on invalid lanes is don't-care.
- Enqueue: `enq = insts_in_valid & ~full`.
  - When set, all `IN_WIDTH` lanes are written at `tail+j mod DEPTH` and `tail += IN_WIDTH`.
  - `insts_in_valid` while `full` is dropped silently. Fetch already gates valid with `stall`.
- Dequeue: `deq_n = decode_stall ? 0 : avail`, and `head += deq_n`.
  - Decode must consume every valid lane when not stalled; partial acceptance is not supported.
- `count_next = count + (enq ? IN_WIDTH : 0) - deq_n`.
  - Enqueue and dequeue in the same cycle are both honoured.
  - `full` is judged on pre-dequeue `count`, so it is conservative.
- Flush takes priority over enqueue and dequeue:
  - `head`, `tail` and `count` go to 0.
  - The input bundle in that cycle is discarded.
  - Output valid is forced low in the flush cycle.
- Reset (`reset_n == 0` at posedge): same effect as flush, and it overrides flush.
  - The memory array is not reset.

## Timing
- Reset values: `entry_count = 0`, `insts_out_valid = 0`, `full = 0`. `insts_out` data is don't-care.
- Latency: a bundle enqueued at edge t appears on `insts_out` in the cycle after t, at the earliest.
- An empty buffer with `insts_in_valid = 1` shows `insts_out_valid = 0` in that cycle.
- Throughput:
  - `min(IN_WIDTH, OUT_WIDTH)` entries/cycle sustained when decode does not stall.
  - `full` never asserts while `IN_WIDTH <= OUT_WIDTH` and decode is not stalled.
- Wrap-around: pointer arithmetic is modulo `DEPTH`. A bundle or read window straddling index `DEPTH-1`→0 must stay in order.
- `full` changes one cycle after the occupancy change that causes it. There is no combinational path from `insts_in_valid` or `decode_stall` to `full`.
- Flush and reset mid-stream: the first cycle after either behaves as an empty buffer. Flush and enqueue in the same cycle leave `count = 0`.

## Test plan
All scenarios use `DEPTH=8`, `IN_WIDTH=2`, `OUT_WIDTH=3`, with `pc` values as labels.

- **Reset then fill:**
  - Stimulus: hold `reset_n=0` 2 cycles, then offer pc 0x0/0x4 with `decode_stall=1`.
  - Required: after reset, `entry_count=0`, `full=0`, `valid=000`. Next cycle `entry_count=2` and `valid=011` with pc 0x0/0x4.
- **Fill to full:**
  - Stimulus: 4 bundles back-to-back with `decode_stall=1`.
  - Required: `entry_count` steps 2,4,6,8. `full=1` once `count=8`. A 5th bundle (pc 0x20) is dropped, and `count` stays 8.
- **Simultaneous enqueue/dequeue:**
  - Stimulus: start at `count=5`, `decode_stall=0`, one bundle offered.
  - Required: 3 dequeued and 2 enqueued, so `count=4`. Output order stays strictly by pc.
- **Wrap-around:**
  - Stimulus: stream 20 sequential instructions (pc 0x0..0x4C) with `decode_stall` toggling every 2 cycles.
  - Required: decode sees all 20 in order with no duplicates or gaps across the index 7→0 wrap.
- **Flush with input:**
  - Stimulus: at `count=6`, assert `flush` together with a valid bundle.
  - Required: `valid=000` in that cycle and `count=0` next cycle. Following bundle pc 0x100/0x104 emerges first.
- **Partial availability:**
  - Stimulus: `count=1`, `decode_stall=0`.
  - Required: `valid=001` and `count` becomes 0. With `count=2`, `valid=011`.
